// File: rtl/alu_serial_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// master drives operands and start; slave returns status, result and flags.
interface alu_serial_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow, zero
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks operands LSB-first through a one-bit slice, WIDTH cycles per op.
// Optional feature: define ALU_SERIAL_SLT_EN to enable signed set-less-than on op 100.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  alu_serial_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SLT = 3'b100
  } op_e;

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_is_add;
  logic             w_is_sub;
  logic             w_is_slt;
  logic             w_in_inv;
  logic             w_inv;
  logic             w_a0;
  logic             w_b0;
  logic             w_sum;
  logic             w_cnext;
  logic             w_ovf;
  logic             w_bit;
  logic [WIDTH-1:0] w_res_final;

  assign w_is_add = (r_op == OP_ADD);
  assign w_is_sub = (r_op == OP_SUB);

`ifdef ALU_SERIAL_SLT_EN
  assign w_is_slt = (r_op == OP_SLT);
  assign w_in_inv = (bus.op == OP_SUB) || (bus.op == OP_SLT);
`else
  assign w_is_slt = 1'b0;
  assign w_in_inv = (bus.op == OP_SUB);
`endif

  assign w_inv    = w_is_sub | w_is_slt;
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // One-bit slice; subtraction is a + ~b + 1 with the +1 preloaded into the carry.
  always_comb begin
    w_a0    = r_a[0];
    w_b0    = r_b[0] ^ w_inv;
    w_sum   = w_a0 ^ w_b0 ^ r_carry;
    w_cnext = (w_a0 & w_b0) | (w_a0 & r_carry) | (w_b0 & r_carry);
    w_ovf   = r_carry ^ w_cnext;
    w_bit   = 1'b0;
    if (r_op == OP_AND) w_bit = w_a0 & w_b0;
    if (r_op == OP_OR)  w_bit = w_a0 | w_b0;
    if (w_is_add || w_is_sub || w_is_slt) w_bit = w_sum;
    w_res_final = {w_bit, r_result[WIDTH-1:1]};
    if (w_is_slt) begin
      w_res_final    = '0;
      w_res_final[0] = w_sum ^ w_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_next == S_RUN);
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_op     <= bus.op;
        r_carry  <= w_in_inv;
        r_cnt    <= '0;
        r_result <= '0;
        r_cout   <= 1'b0;
        r_ovf    <= 1'b0;
        r_zero   <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_cnext;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_result <= w_res_final;
          r_zero   <= (w_res_final == '0);
          r_ovf    <= (w_is_add || w_is_sub) ? w_ovf : 1'b0;
          r_cout   <= w_is_add ? w_cnext : (w_is_sub ? ~w_cnext : 1'b0);
        end else begin
          r_result <= {w_bit, r_result[WIDTH-1:1]};
        end
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH = 32).
module tb_alu_serial_seq;
  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op; lat = edges from accept to done (0 if done never came).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.overflow, bus.zero} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.busy, bus.done, bus.cout, bus.overflow, bus.zero});
    end
    total++;
    if (bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_result got=%h want=00000000", bus.result);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors();
    logic [2:0]  v_op  [10];
    logic [31:0] v_a   [10];
    logic [31:0] v_b   [10];
    logic [31:0] v_res [10];
    logic [2:0]  v_fl  [10];  // {cout, overflow, zero}
    int lat;
    v_op[0] = 3'b010; v_a[0] = 32'hFFFFFFFF; v_b[0] = 32'h00000001; v_res[0] = 32'h00000000; v_fl[0] = 3'b101;
    v_op[1] = 3'b011; v_a[1] = 32'd5;        v_b[1] = 32'd7;        v_res[1] = 32'hFFFFFFFE; v_fl[1] = 3'b100;
    v_op[2] = 3'b010; v_a[2] = 32'h7FFFFFFF; v_b[2] = 32'h00000001; v_res[2] = 32'h80000000; v_fl[2] = 3'b010;
    v_op[3] = 3'b000; v_a[3] = 32'hF0F0F0F0; v_b[3] = 32'hFF00FF00; v_res[3] = 32'hF000F000; v_fl[3] = 3'b000;
    v_op[4] = 3'b001; v_a[4] = 32'hF0F0F0F0; v_b[4] = 32'hFF00FF00; v_res[4] = 32'hFFF0FFF0; v_fl[4] = 3'b000;
    v_op[5] = 3'b110; v_a[5] = 32'h12345678; v_b[5] = 32'h9ABCDEF0; v_res[5] = 32'h00000000; v_fl[5] = 3'b001;
    v_op[6] = 3'b011; v_a[6] = 32'd9;        v_b[6] = 32'd9;        v_res[6] = 32'h00000000; v_fl[6] = 3'b001;
    v_op[7] = 3'b011; v_a[7] = 32'h80000000; v_b[7] = 32'h00000001; v_res[7] = 32'h7FFFFFFF; v_fl[7] = 3'b010;
`ifdef ALU_SERIAL_SLT_EN
    v_op[8] = 3'b100; v_a[8] = 32'hFFFFFFFF; v_b[8] = 32'h00000001; v_res[8] = 32'h00000001; v_fl[8] = 3'b000;
    v_op[9] = 3'b100; v_a[9] = 32'h80000000; v_b[9] = 32'h7FFFFFFF; v_res[9] = 32'h00000001; v_fl[9] = 3'b000;
`else
    v_op[8] = 3'b100; v_a[8] = 32'hFFFFFFFF; v_b[8] = 32'h00000001; v_res[8] = 32'h00000000; v_fl[8] = 3'b001;
    v_op[9] = 3'b100; v_a[9] = 32'h80000000; v_b[9] = 32'h7FFFFFFF; v_res[9] = 32'h00000000; v_fl[9] = 3'b001;
`endif
    for (int i = 0; i < 10; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], lat);
      total++;
      if (lat !== 32) begin
        bad++;
        $display("FAIL vec%0d_latency got=%0d want=32", i, lat);
      end
      total++;
      if (bus.result !== v_res[i]) begin
        bad++;
        $display("FAIL vec%0d_result got=%h want=%h", i, bus.result, v_res[i]);
      end
      total++;
      if ({bus.cout, bus.overflow, bus.zero} !== v_fl[i]) begin
        bad++;
        $display("FAIL vec%0d_flags(c,v,z) got=%b want=%b", i,
                 {bus.cout, bus.overflow, bus.zero}, v_fl[i]);
      end
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_busy_in_done got=%b want=0", i, bus.busy);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd10; bus.b = 32'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ignore_busy_after_accept got=%b want=1", bus.busy);
    end
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'h0; bus.b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    for (int n = 8; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    total++;
    if (lat !== 32) begin
      bad++;
      $display("FAIL ignore_latency got=%0d want=32", lat);
    end
    total++;
    if (bus.result !== 32'd30) begin
      bad++;
      $display("FAIL ignore_result got=%h want=0000001e", bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(3'b010, 32'd1, 32'd2, lat);
    total++;
    if (lat !== 32 || bus.result !== 32'd3) begin
      bad++;
      $display("FAIL b2b_first got lat=%0d res=%h want lat=32 res=00000003", lat, bus.result);
    end
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 32'd10; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
    end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    total++;
    if (lat !== 32 || bus.result !== 32'd7) begin
      bad++;
      $display("FAIL b2b_second got lat=%0d res=%h want lat=32 res=00000007", lat, bus.result);
    end
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0 || bus.result !== 32'd7) begin
      bad++;
      $display("FAIL b2b_pulse_hold got done=%b res=%h want done=0 res=00000007", bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd200;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.overflow, bus.zero} !== 5'b0 || bus.result !== 32'h0) begin
      bad++;
      $display("FAIL midreset_clear got flags=%b res=%h want flags=00000 res=00000000",
               {bus.busy, bus.done, bus.cout, bus.overflow, bus.zero}, bus.result);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midreset_no_done got done_seen=%b want=0", seen);
    end
    run_op(3'b010, 32'd3, 32'd4, lat);
    total++;
    if (lat !== 32 || bus.result !== 32'd7) begin
      bad++;
      $display("FAIL midreset_fresh got lat=%0d res=%h want lat=32 res=00000007", lat, bus.result);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Multi-cycle bit-serial ALU sequencer. It accepts full-width operands and an opcode, then walks them LSB-first through a one-bit slice datapath (AND/OR/full-adder, plus a carry flip-flop), one bit per clock. It assembles the full-width result and flags and presents them with a done pulse. It is the driver side of the bit-slice ALU: it owns the carry chain and bit sequencing that the combinational slice leaves to its user. It is intended for area-constrained datapaths that tolerate WIDTH-cycle latency.

## Interface
- WIDTH, 32: operand/result width in bits, must be ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled only when busy = 0.
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101–111 reserved.
- a  input  WIDTH  operand A, latched on accept.
- b  input  WIDTH  operand B, latched on accept.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  final result, held until the next accept.
- cout  output  1  ADD: carry out of MSB. SUB: borrow (1 iff a < b unsigned). Otherwise 0.
- overflow  output  1  signed overflow for ADD/SUB. Otherwise 0.
- zero  output  1  result == 0.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; every output 0; internal registers 0.
- **Accept:** on a clock edge with start = 1 and state ∈ {IDLE, DONE}:
  - latch a, b, op;
  - set carry = 1 for SUB/SLT, else 0;
  - clear the bit counter;
  - clear result, cout, overflow, zero;
  - go to RUN.
- **Per-bit step in RUN:** on each edge take bit a0 and bit b0 (b0 is inverted for SUB/SLT) and compute:
  - AND → a0 & b0;
  - OR → a0 | b0;
  - ADD/SUB/SLT → a0 ^ b0' ^ carry;
  - then update carry = majority(a0, b0', carry);
  - shift the output bit into result from the MSB side;
  - shift the operands right by one;
  - increment the counter.
- **Final step:** when counter = WIDTH-1, the step finalizes the flags and moves to DONE.
  - overflow = carry into MSB ^ carry out.
  - cout: ADD → carry out; SUB → ~carry out.
  - SLT: result = {WIDTH-1 zeros, sum MSB ^ overflow}; cout and overflow read 0.
  - zero is computed from the final result value.
- **Reserved ops:** run the same WIDTH cycles; result, cout, overflow = 0; zero = 1.
- **DONE:** done = 1 for exactly this cycle; busy = 0. Without start → IDLE; with start → accept (back-to-back).
- **start while busy:** ignored, no queuing; the in-flight operation is unaffected.
- **Input changes:** a, b, op changing after accept have no effect.
- **reset mid-operation:** immediate return to IDLE; all outputs 0; no done pulse.

## Timing
- Start sampled at edge k:
  - busy = 1 from edge k through edge k+WIDTH;
  - done = 1 from edge k+WIDTH to k+WIDTH+1;
  - latency is WIDTH+1 edges, start to the end of done.
- Throughput: one operation per WIDTH+1 cycles with back-to-back start.
- All outputs are registered; no combinational path from inputs to outputs.
- result, cout, overflow, zero are stable from the done cycle until the next accept edge.

## Configuration
- ALU_SERIAL_SLT_EN
  - **Defined:** op 100 performs signed set-less-than as above.
  - **Undefined:** op 100 is treated as reserved (result 0, zero 1, same latency), and the SLT logic is removed.

## Test plan
- **ADD wrap:** WIDTH=32, ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, cout 1, overflow 0, zero 1; done exactly 32 edges after the accept edge.
- **SUB borrow / ADD overflow:**
  - SUB 5 − 7 → result 0xFFFFFFFE, cout 1, overflow 0.
  - ADD 0x7FFFFFFF + 1 → 0x80000000, overflow 1, cout 0.
- **SLT:** a = 0xFFFFFFFF (−1), b = 1.
  - Macro defined → result 0x00000001.
  - Macro undefined → 0x00000000, zero 1.
  - a = 0x80000000, b = 0x7FFFFFFF (overflow case) → 1 with macro.
- **AND/OR and reserved:**
  - AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000.
  - OR same operands → 0xFFF0FFF0.
  - op 110 → result 0, zero 1, done after the same latency.
- **Handshake:**
  - start pulsed mid-run with different operands → ignored; the first result is correct.
  - start held high in the done cycle → the second op is accepted immediately, with a second done pulse 32 edges later.
- **Reset:** assert reset while the counter is at bit 10 → busy, done, result, flags are 0 immediately; no done pulse; a fresh start afterward completes normally.
